// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction split/align, predicted-PC register and sticky-halt FSM.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        F_stall,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    output logic [3:0]  f_icode,
    output logic [3:0]  f_ifun,
    output logic [3:0]  f_rA,
    output logic [3:0]  f_rB,
    output logic [63:0] f_valC,
    output logic [63:0] f_valP,
    output logic [3:0]  f_stat,
    output logic [63:0] f_predPC
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_redirects
`endif
);

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;
    localparam logic [3:0] I_MAX  = 4'hB;
    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [3:0] S_AOK = 4'd1;
    localparam logic [3:0] S_HLT = 4'd2;
    localparam logic [3:0] S_ADR = 4'd3;
    localparam logic [3:0] S_INS = 4'd4;

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q;
    logic [63:0] pred_pc_q;

    logic        mispredict;
    logic        ret_taken;
    logic        redirect;
    logic [63:0] f_pc;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [3:0]  raw_icode;
    logic        need_regids;
    logic        need_valC;
    logic [63:0] dec_valC;
    logic [63:0] dec_valP;
    logic [3:0]  dec_stat;

    assign mispredict = (M_icode == I_JXX) && !M_Cnd;
    assign ret_taken  = (W_icode == I_RET);
    assign redirect   = mispredict || ret_taken;
    assign f_pc       = mispredict ? M_valA : (ret_taken ? W_valM : pred_pc_q);
    assign imem_addr  = f_pc;

    assign byte0     = imem_data[7:0];
    assign byte1     = imem_data[15:8];
    assign raw_icode = byte0[7:4];

    always_comb begin
        need_regids = 1'b0;
        need_valC   = 1'b0;
        case (raw_icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regids = 1'b1;
                need_valC   = 1'b1;
            end
            4'h7, 4'h8:             need_valC   = 1'b1;
            default: ;
        endcase
    end

    // The constant sits one byte later when a register-specifier byte precedes it.
    assign dec_valC = !need_valC ? 64'h0 :
                      (need_regids ? imem_data[79:16] : imem_data[71:8]);
    assign dec_valP = f_pc + 64'd1 + {63'd0, need_regids} + {60'd0, need_valC, 3'b000};

    always_comb begin
        if (imem_error)              dec_stat = S_ADR;
        else if (raw_icode > I_MAX)  dec_stat = S_INS;
        else if (raw_icode == I_HALT) dec_stat = S_HLT;
        else                         dec_stat = S_AOK;
    end

    // A redirect out of HALTED decodes the redirect target normally in the same cycle.
    always_comb begin
        f_icode  = raw_icode;
        f_ifun   = byte0[3:0];
        f_rA     = need_regids ? byte1[7:4] : R_NONE;
        f_rB     = need_regids ? byte1[3:0] : R_NONE;
        f_valC   = dec_valC;
        f_valP   = dec_valP;
        f_stat   = dec_stat;
        f_predPC = (raw_icode == I_JXX || raw_icode == I_CALL) ? dec_valC : dec_valP;
        if (imem_error) begin
            f_icode = I_NOP;
            f_ifun  = 4'h0;
        end
        if (state_q == HALTED && !redirect) begin
            f_icode  = I_NOP;
            f_ifun   = 4'h0;
            f_rA     = R_NONE;
            f_rB     = R_NONE;
            f_valC   = 64'h0;
            f_valP   = pred_pc_q;
            f_stat   = S_AOK;
            f_predPC = pred_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pred_pc_q <= RESET_PC;
        end else if (!F_stall) begin
            case (state_q)
                RUN: begin
                    pred_pc_q <= f_predPC;
                    if (f_stat != S_AOK && !redirect)
                        state_q <= HALTED;
                end
                HALTED: begin
                    if (redirect) begin
                        pred_pc_q <= f_predPC;
                        state_q   <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stalls_q;
    logic [31:0] redirects_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q   <= 32'd0;
            stalls_q    <= 32'd0;
            redirects_q <= 32'd0;
        end else begin
            fetched_q   <= sat_inc(fetched_q, !F_stall && state_q == RUN);
            stalls_q    <= sat_inc(stalls_q, F_stall);
            redirects_q <= sat_inc(redirects_q, redirect && !F_stall);
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_stalls    = stalls_q;
    assign perf_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus randomized traffic against a
// transaction-level reference model. Counter checks are included when FETCH_PERF_EN is defined.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        F_stall = 1'b0;
    logic [3:0]  M_icode = 4'h0;
    logic        M_Cnd = 1'b1;
    logic [63:0] M_valA = 64'h0;
    logic [3:0]  W_icode = 4'h0;
    logic [63:0] W_valM = 64'h0;
    logic [63:0] imem_addr;
    logic [79:0] imem_data = 80'h10;
    logic        imem_error = 1'b0;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB, f_stat;
    logic [63:0] f_valC, f_valP, f_predPC;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls, perf_redirects;
    int unsigned m_fetched = 0, m_stalls = 0, m_redirs = 0;
`endif

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [79:0] NOP_W  = 80'h10;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .F_stall(F_stall),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .imem_addr(imem_addr), .imem_data(imem_data), .imem_error(imem_error),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat), .f_predPC(f_predPC)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls), .perf_redirects(perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode, ifun, rA, rB, stat;
        logic [63:0] valC, valP, pred, addr;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] m_pc = RST_PC;
    bit          m_halted = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: instruction length from the Y86 encoding table, fetch PC from redirect priority.
    function automatic exp_t model(input logic [3:0] mi, input bit mc, input logic [63:0] ma,
                                   input logic [3:0] wi, input logic [63:0] wm,
                                   input logic [79:0] d, input bit er, output bit redir);
        exp_t e;
        bit mis, ret, regs, cst;
        logic [3:0] ic;
        logic [63:0] pc;
        mis   = (mi == 4'd7) && !mc;
        ret   = (wi == 4'd9);
        redir = mis || ret;
        pc    = mis ? ma : (ret ? wm : m_pc);
        e.addr = pc;
        e.err  = 1'b0;
        if (m_halted && !redir) begin
            e.icode = 4'd1; e.ifun = 4'd0; e.rA = 4'hF; e.rB = 4'hF;
            e.valC = 64'd0; e.valP = m_pc; e.stat = 4'd1; e.pred = m_pc;
            return e;
        end
        ic = d[7:4];
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: begin regs = 1; cst = 0; end
            4'h3, 4'h4, 4'h5:       begin regs = 1; cst = 1; end
            4'h7, 4'h8:             begin regs = 0; cst = 1; end
            default:                begin regs = 0; cst = 0; end
        endcase
        e.icode = er ? 4'd1 : ic;
        e.ifun  = er ? 4'd0 : d[3:0];
        e.rA    = regs ? d[15:12] : 4'hF;
        e.rB    = regs ? d[11:8]  : 4'hF;
        e.valC  = !cst ? 64'd0 : (regs ? d[79:16] : d[71:8]);
        e.valP  = pc + 64'd1 + (regs ? 64'd1 : 64'd0) + (cst ? 64'd8 : 64'd0);
        e.stat  = er ? 4'd3 : (ic > 4'hB ? 4'd4 : (ic == 4'h0 ? 4'd2 : 4'd1));
        e.pred  = (ic == 4'h7 || ic == 4'h8) ? e.valC : e.valP;
        e.err   = er;
        return e;
    endfunction

    task automatic apply(input bit st, input logic [3:0] mi, input bit mc, input logic [63:0] ma,
                         input logic [3:0] wi, input logic [63:0] wm,
                         input logic [79:0] d, input bit er);
        exp_t e;
        bit redir;
        F_stall = st; M_icode = mi; M_Cnd = mc; M_valA = ma;
        W_icode = wi; W_valM = wm; imem_data = d; imem_error = er;
        e = model(mi, mc, ma, wi, wm, d, er, redir);
        sb.push_back(e);
`ifdef FETCH_PERF_EN
        if (!st && !m_halted) m_fetched++;
        if (st) m_stalls++;
        if (redir && !st) m_redirs++;
`endif
        if (!st) begin
            if (m_halted) begin
                if (redir) begin m_halted = 1'b0; m_pc = e.pred; end
            end else begin
                m_pc = e.pred;
                if (e.stat != 4'd1 && !redir) m_halted = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic [79:0] d, input bit er);
        apply(1'b0, 4'h0, 1'b1, 64'h0, 4'h0, 64'h0, d, er);
    endtask

    always begin
        @(negedge clk);
        #2;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("f_icode", {60'd0, f_icode}, {60'd0, e.icode});
            chk("f_ifun", {60'd0, f_ifun}, {60'd0, e.ifun});
            chk("f_stat", {60'd0, f_stat}, {60'd0, e.stat});
            if (!e.err) begin
                chk("f_rA", {60'd0, f_rA}, {60'd0, e.rA});
                chk("f_rB", {60'd0, f_rB}, {60'd0, e.rB});
                chk("f_valC", f_valC, e.valC);
                chk("f_valP", f_valP, e.valP);
                chk("f_predPC", f_predPC, e.pred);
            end
        end
    end

`ifdef FETCH_PERF_EN
    task automatic chk_perf();
        chk("perf_fetched", {32'd0, perf_fetched}, {32'd0, m_fetched});
        chk("perf_stalls", {32'd0, perf_stalls}, {32'd0, m_stalls});
        chk("perf_redirects", {32'd0, perf_redirects}, {32'd0, m_redirs});
    endtask
`endif

    initial begin
        logic [63:0] hold_pc;
        logic [79:0] d;
        int r;

        #12;
        chk("reset_addr", imem_addr, RST_PC);
`ifdef FETCH_PERF_EN
        chk_perf();
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // irmovq with rB=2, valC=5
        idle({64'd5, 8'hF2, 8'h30}, 1'b0);
        #3;
        chk("t1_icode", {60'd0, f_icode}, 64'd3);
        chk("t1_rB", {60'd0, f_rB}, 64'd2);
        chk("t1_valC", f_valC, 64'd5);
        chk("t1_valP", f_valP, 64'd10);
        chk("t1_stat", {60'd0, f_stat}, 64'd1);
        @(negedge clk);
        idle(NOP_W, 1'b0);
        #3 chk("t1_nextpc", imem_addr, 64'd10);
        @(negedge clk);

        // jXX at PC 0, then mispredict back to fall-through
        apply(1'b0, 4'h7, 1'b0, 64'h0, 4'h0, 64'h0, {8'h00, 64'h40, 8'h70}, 1'b0);
        #3;
        chk("t2_valP", f_valP, 64'd9);
        chk("t2_pred", f_predPC, 64'h40);
        @(negedge clk);
        apply(1'b0, 4'h7, 1'b0, 64'd9, 4'h0, 64'h0, NOP_W, 1'b0);
        #3 chk("t2_mispred", imem_addr, 64'd9);
        @(negedge clk);

        // ret, then ret together with mispredict
        apply(1'b0, 4'h0, 1'b1, 64'h0, 4'h9, 64'h100, NOP_W, 1'b0);
        #3 chk("t3_ret", imem_addr, 64'h100);
        @(negedge clk);
        apply(1'b0, 4'h7, 1'b0, 64'h200, 4'h9, 64'h100, NOP_W, 1'b0);
        #3 chk("t3_prio", imem_addr, 64'h200);
        @(negedge clk);

        // halt, sticky for 5 cycles, then mispredict resumes
        idle(80'h00, 1'b0);
        #3 chk("t4_hlt", {60'd0, f_stat}, 64'd2);
        @(negedge clk);
        hold_pc = m_pc;
        for (int i = 0; i < 5; i++) begin
            idle(NOP_W, 1'b0);
            #3;
            chk("t4_halt_icode", {60'd0, f_icode}, 64'd1);
            chk("t4_halt_stat", {60'd0, f_stat}, 64'd1);
            chk("t4_halt_addr", imem_addr, hold_pc);
            @(negedge clk);
        end
        apply(1'b0, 4'h7, 1'b0, 64'h300, 4'h0, 64'h0, NOP_W, 1'b0);
        #3 chk("t4_resume", imem_addr, 64'h300);
        @(negedge clk);
        idle(NOP_W, 1'b0);
        #3 chk("t4_run", imem_addr, 64'h301);
        @(negedge clk);

        // imem_error, invalid icode via redirect, then stall
        idle(NOP_W, 1'b1);
        #3;
        chk("t5_adr_stat", {60'd0, f_stat}, 64'd3);
        chk("t5_adr_icode", {60'd0, f_icode}, 64'd1);
        @(negedge clk);
        apply(1'b0, 4'h7, 1'b0, 64'h400, 4'h0, 64'h0, 80'hC0, 1'b0);
        #3 chk("t5_ins", {60'd0, f_stat}, 64'd4);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 4'h0, 1'b1, 64'h0, 4'h0, 64'h0, NOP_W, 1'b0);
            #3 chk("t5_stall_addr", imem_addr, 64'h401);
            @(negedge clk);
        end
        idle(NOP_W, 1'b0);
        @(negedge clk);

        // async reset while halted
        idle(80'h00, 1'b0);
        @(negedge clk);
        idle(NOP_W, 1'b0);
        #3 rst_n = 1'b0;
        #1 chk("t6_async_rst", imem_addr, RST_PC);
`ifdef FETCH_PERF_EN
        m_fetched = 0; m_stalls = 0; m_redirs = 0;
        chk_perf();
`endif
        m_pc = RST_PC;
        m_halted = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 2000; n++) begin
            logic [3:0] mi, wi, ic;
            bit mc, st, er;
            d[31:0]  = $urandom;
            d[63:32] = $urandom;
            d[79:64] = 16'($urandom);
            r = $urandom_range(0, 99);
            if (r < 4)      ic = 4'h0;
            else if (r < 8) ic = 4'($urandom_range(12, 15));
            else            ic = 4'($urandom_range(1, 11));
            d[7:4] = ic;
            st = ($urandom_range(0, 99) < 20);
            er = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 10) begin mi = 4'h7; mc = 1'b0; end
            else begin mi = 4'($urandom_range(0, 15)); mc = 1'($urandom); end
            wi = ($urandom_range(0, 99) < 10) ? 4'h9 : 4'($urandom_range(0, 8));
            apply(st, mi, mc, {$urandom, $urandom}, wi, {$urandom, $urandom}, d, er);
            @(negedge clk);
        end
        idle(NOP_W, 1'b0);
        @(negedge clk);
        #3;
`ifdef FETCH_PERF_EN
        chk_perf();
`endif
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
